alu_issue_seq: RTL
==================

Name: alu_issue_seq

Overview:
- Execute-stage sequencer that drives the existing combinational ALU.
- Accepts decoded instructions with pre-read register values over a valid/ready handshake and evaluates the ARM condition code against its own flag register.
- Drives LHS/RHS/uop into the ALU, captures out_alu and flags, and issues a register-file write-back.
- Sits between decode/regread and the ALU/regfile.

Parameters:
- DATA_W, 32, operand/result width (matches ALU).
- RADDR_W, 4, destination register index width (r0-r15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept
- in_uop  in  5  micro-op, ALU encoding (0 NOP, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 CMP, 6 LSL, 7 LSR, 8 MOV)
- in_cond  in  4  ARM condition field
- in_set_flags  in  1  S bit
- in_rd  in  RADDR_W  destination register
- in_lhs  in  DATA_W  first operand value
- in_rhs  in  DATA_W  second operand / immediate
- LHS  out  DATA_W  to ALU
- RHS  out  DATA_W  to ALU
- uop  out  5  to ALU
- out_alu  in  DATA_W  from ALU
- flags  in  4  from ALU, order [Z, C, N, V]
- wb_en  out  1  register write strobe
- wb_rd  out  RADDR_W  write index
- wb_data  out  DATA_W  write data
- flags_q  out  4  architectural flags [Z, C, N, V]

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - State IDLE; all internal registers cleared.
  - Outputs: LHS=0, RHS=0, uop=0, wb_en=0, wb_rd=0, wb_data=0, flags_q=0.
  - in_ready=0 while rst is high.
  - Reset mid-operation drops the in-flight instruction: no write-back, no flag update.
- States: IDLE, EXEC, WB.
  - IDLE: in_ready=1. On in_valid & in_ready, latch uop/cond/S/rd/lhs/rhs, then go to EXEC.
  - EXEC: in_ready=0. Evaluate cond against flags_q.
    - Pass: drive LHS/RHS/uop from the latched values.
    - Fail: drive uop=0 and LHS=RHS=0.
    - At the clock edge: capture out_alu into wb_data and rd into wb_rd, update flags if required, then go to WB.
  - WB:
    - wb_en=1 for exactly this one cycle, only if cond passed and uop is in {1,2,3,4,6,7,8}.
    - in_ready=1. A handshake in WB goes directly to EXEC (back-to-back issue, one instruction per 2 cycles); otherwise go to IDLE.
- Latency: accept edge at cycle 0, ALU driven during cycle 1, wb_en high during cycle 2.
- LHS/RHS/uop are held at 0 in IDLE and WB; they are non-zero only in EXEC.
- Flag update, at the end of EXEC, only when the condition passed:
  - CMP always updates flags_q from flags.
  - Other uops update it only if in_set_flags=1.
  - NOP never updates it.
- Flags are visible to the following instruction's condition evaluation, since its EXEC is at least one cycle later.
- Condition table:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL (1110) always passes; 1111 never passes.
- Illegal uop (9-31): treated as NOP. No write-back, no flag update, ALU driven with uop=0.
- rd=15 is written like any other register; PC semantics are the regfile's concern.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined, adds two outputs:
  - perf_retired (32): increments at the end of each EXEC whose condition passed.
  - perf_skipped (32): increments at the end of each EXEC whose condition failed or whose uop was illegal.
- Both counters clear on rst and wrap modulo 2^32.
- When not defined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - uop constants (UOP_NOP..UOP_MOV);
  - condition constants (COND_EQ..COND_NV);
  - flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0);
  - the state encoding.
- One natural sub-module: cond_check. It is combinational, with inputs cond[3:0] and flags[3:0] and output pass. It is reused later by branch logic.

Test Plan (the bench instantiates ALU alongside the sequencer):
- ADD with lhs=0, rhs=1, rd=3, cond=AL, S=0 -> in cycle 2, wb_en=1, wb_rd=3, wb_data=0x00000001; flags_q stays 0000.
- CMP with lhs=1, rhs=1, cond=AL -> no wb_en; flags_q Z=1. Then MOV rhs=0x12345678 rd=5 cond=EQ issued back-to-back from WB -> wb_data=0x12345678, wb_rd=5.
- With Z=1, MOV cond=NE -> uop stays 0 during EXEC, no wb_en, flags_q unchanged; perf_skipped=1 when the feature is enabled.
- SUB with lhs=1, rhs=1, S=1 -> wb_data=0, flags_q Z=1. Then LSR with lhs=0x80000000, rhs=1, S=0 -> wb_data=0x40000000, flags_q still Z=1.
- Assert rst during EXEC of XOR with lhs=0xAAAAAAAA, rhs=0x55555555 -> next cycle: IDLE, wb_en never asserted, flags_q=0, uop=0.
- Illegal uop=5'h1F with cond=AL -> no wb_en, no flag change, ALU uop=0; the sequencer accepts the next instruction normally.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer and related execute-stage logic.
// Holds the ALU micro-op encoding, ARM condition codes, flag bit positions,
// the sequencer state encoding and small uop classification helpers.
package alu_issue_seq_pkg;

   localparam logic [4:0] UOP_NOP = 5'd0;
   localparam logic [4:0] UOP_ADD = 5'd1;
   localparam logic [4:0] UOP_SUB = 5'd2;
   localparam logic [4:0] UOP_AND = 5'd3;
   localparam logic [4:0] UOP_XOR = 5'd4;
   localparam logic [4:0] UOP_CMP = 5'd5;
   localparam logic [4:0] UOP_LSL = 5'd6;
   localparam logic [4:0] UOP_LSR = 5'd7;
   localparam logic [4:0] UOP_MOV = 5'd8;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Flag vector order is [Z, C, N, V]
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Encodings 9..31 are illegal and behave as NOP
   function automatic logic uop_legal(input logic [4:0] u);
      return (u <= UOP_MOV);
   endfunction

   // Uops that produce a register result
   function automatic logic uop_writes(input logic [4:0] u);
      return (u == UOP_ADD) || (u == UOP_SUB) || (u == UOP_AND) || (u == UOP_XOR) ||
             (u == UOP_LSL) || (u == UOP_LSR) || (u == UOP_MOV);
   endfunction

endpackage

// File: rtl/alu_issue_seq_cond_check.sv
// cond_check: combinational ARM condition-code evaluator.
// Ports:
//   cond  [3:0]  ARM condition field
//   flags [3:0]  flag vector [Z, C, N, V]
//   pass         1 when the condition holds (AL always, NV never)
module cond_check
   import alu_issue_seq_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic z, c, n, v;

   always_comb begin
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      n = flags[FLAG_N];
      v = flags[FLAG_V];
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: execute-stage sequencer driving the combinational ALU.
// Accepts decoded instructions over valid/ready, evaluates the condition code
// against its flag register, drives the ALU for one cycle and issues a
// register-file write-back. IDLE -> EXEC -> WB, back-to-back issue from WB.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       instruction handshake
//   in_uop, in_cond, in_set_flags, in_rd, in_lhs, in_rhs   decoded instruction
//   LHS, RHS, uop             ALU operands and micro-op (non-zero only in EXEC)
//   out_alu, flags            ALU result and flags [Z, C, N, V]
//   wb_en, wb_rd, wb_data     register write-back (wb_en pulses in WB)
//   flags_q                   architectural flags [Z, C, N, V]
// Optional: define ALU_ISSUE_PERF_EN to add perf_retired / perf_skipped counters.
module alu_issue_seq
   import alu_issue_seq_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         in_uop,
   input  logic [3:0]         in_cond,
   input  logic               in_set_flags,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0]  in_lhs,
   input  logic [DATA_W-1:0]  in_rhs,
   output logic [DATA_W-1:0]  LHS,
   output logic [DATA_W-1:0]  RHS,
   output logic [4:0]         uop,
   input  logic [DATA_W-1:0]  out_alu,
   input  logic [3:0]         flags,
   output logic               wb_en,
   output logic [RADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0]  wb_data,
   output logic [3:0]         flags_q
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]        perf_retired,
   output logic [31:0]        perf_skipped
`endif
);

   state_t             state;
   logic [4:0]         uop_q;
   logic [RADDR_W-1:0] rd_q;
   logic               set_q;
   logic               pass_q;
   logic               cond_pass;
   logic               accept;
   logic               flag_upd;

   // Evaluated at the accept edge: flags_q cannot change between accept and
   // EXEC, so the outcome equals evaluation during EXEC while letting the ALU
   // drive signals come straight from registers.
   cond_check u_cond_check (
      .cond  (in_cond),
      .flags (flags_q),
      .pass  (cond_pass)
   );

   assign in_ready = !rst && ((state == ST_IDLE) || (state == ST_WB));
   assign accept   = in_valid && in_ready;
   assign flag_upd = pass_q && uop_legal(uop_q) && (uop_q != UOP_NOP) &&
                     ((uop_q == UOP_CMP) || set_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         uop_q   <= '0;
         rd_q    <= '0;
         set_q   <= 1'b0;
         pass_q  <= 1'b0;
         LHS     <= '0;
         RHS     <= '0;
         uop     <= '0;
         wb_en   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
         flags_q <= '0;
`ifdef ALU_ISSUE_PERF_EN
         perf_retired <= '0;
         perf_skipped <= '0;
`endif
      end else begin
         LHS   <= '0;
         RHS   <= '0;
         uop   <= '0;
         wb_en <= 1'b0;
         case (state)
            ST_IDLE, ST_WB: begin
               if (accept) begin
                  uop_q  <= in_uop;
                  rd_q   <= in_rd;
                  set_q  <= in_set_flags;
                  pass_q <= cond_pass;
                  if (cond_pass && uop_legal(in_uop)) begin
                     LHS <= in_lhs;
                     RHS <= in_rhs;
                     uop <= in_uop;
                  end
                  state <= ST_EXEC;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               wb_data <= out_alu;
               wb_rd   <= rd_q;
               wb_en   <= pass_q && uop_writes(uop_q);
               if (flag_upd) flags_q <= flags;
`ifdef ALU_ISSUE_PERF_EN
               if (pass_q && uop_legal(uop_q)) perf_retired <= perf_retired + 32'd1;
               else                            perf_skipped <= perf_skipped + 32'd1;
`endif
               state <= ST_WB;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
